// File: rtl/txarbiter_if.sv
// Requester-side and txdata-side handshake bundle for the round-robin transmit arbiter.
// The arbiter uses the slave view; the producers/txdata side uses the master view.
interface txarbiter_if #(
    parameter int NREQ   = 4,
    parameter int LGNREQ = 2
);
    logic [NREQ-1:0]        i_req_stb;
    logic [NREQ-1:0][31:0]  i_req_data;
    logic [NREQ-1:0]        o_req_busy;
    logic                   o_tx_stb;
    logic [31:0]            o_tx_data;
    logic                   i_tx_busy;
    logic [LGNREQ-1:0]      o_grant;
    logic                   o_active;

    modport slave (
        input  i_req_stb, i_req_data, i_tx_busy,
        output o_req_busy, o_tx_stb, o_tx_data, o_grant, o_active
    );

    modport master (
        output i_req_stb, i_req_data, i_tx_busy,
        input  o_req_busy, o_tx_stb, o_tx_data, o_grant, o_active
    );
endinterface

// File: rtl/txarbiter.sv
// Round-robin arbiter sharing one txdata word transmitter among NREQ producers,
// each with a one-word holding buffer using the same stb/busy handshake.
module txarbiter_slot (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stb,
    input  logic [31:0] i_data,
    input  logic        i_clr,
    output logic        o_busy,
    output logic [31:0] o_data
);
    // A load needs !o_busy, so a load and a clear can never collide.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_busy <= 1'b0;
            o_data <= '0;
        end else if (i_stb && !o_busy) begin
            o_busy <= 1'b1;
            o_data <= i_data;
        end else if (i_clr) begin
            o_busy <= 1'b0;
        end
    end
endmodule

module txarbiter #(
    parameter int NREQ   = 4,
    parameter int LGNREQ = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    txarbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SEND, GUARD, WAIT} state_t;

    state_t                 state, state_nxt;
    logic [NREQ-1:0]        full, clr;
    logic [NREQ-1:0][31:0]  word;
    logic [LGNREQ-1:0]      pick, idx;
    logic [LGNREQ-1:0]      grant_nxt;
    logic [31:0]            data_nxt;
    logic                   stb_nxt;
    logic                   xfer;

    assign xfer = bus.o_tx_stb && !bus.i_tx_busy;

    genvar k;
    generate
        for (k = 0; k < NREQ; k++) begin : g_slot
            txarbiter_slot u_slot (
                .i_clk   (i_clk),
                .i_reset (i_reset),
                .i_stb   (bus.i_req_stb[k]),
                .i_data  (bus.i_req_data[k]),
                .i_clr   (clr[k]),
                .o_busy  (full[k]),
                .o_data  (word[k])
            );
        end
    endgenerate

    assign bus.o_req_busy = full;

    // Walk offsets from farthest to nearest so the first full buffer after o_grant wins.
    always_comb begin
        pick = bus.o_grant;
        idx  = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = LGNREQ'((int'(bus.o_grant) + i) % NREQ);
            if (full[idx])
                pick = idx;
        end
    end

    always_comb begin
        state_nxt = state;
        stb_nxt   = bus.o_tx_stb;
        data_nxt  = bus.o_tx_data;
        grant_nxt = bus.o_grant;
        clr       = '0;
        case (state)
            IDLE: begin
                if (|full) begin
                    grant_nxt = pick;
                    data_nxt  = word[pick];
                    stb_nxt   = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    stb_nxt   = 1'b0;
                    clr       = NREQ'(1) << bus.o_grant;
                    state_nxt = GUARD;
                end
            end
            // txdata raises busy only the cycle after a transfer, so skip one sample.
            GUARD: state_nxt = WAIT;
            WAIT: begin
                if (!bus.i_tx_busy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            bus.o_tx_stb  <= 1'b0;
            bus.o_tx_data <= '0;
            bus.o_grant   <= LGNREQ'(NREQ - 1);
            bus.o_active  <= 1'b0;
        end else begin
            state         <= state_nxt;
            bus.o_tx_stb  <= stb_nxt;
            bus.o_tx_data <= data_nxt;
            bus.o_grant   <= grant_nxt;
            bus.o_active  <= (state_nxt != IDLE);
        end
    end
endmodule

// File: tb/tb_txarbiter.sv
// Bench for txarbiter: cycle table for the single-word timeline, scoreboard of
// {grant, word} for every transfer, plus hand sequences for stall/fairness/reset.
module tb_txarbiter;
    localparam int NREQ    = 4;
    localparam int LGNREQ  = 2;
    localparam int BUSYLEN = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    txarbiter_if #(.NREQ(NREQ), .LGNREQ(LGNREQ)) bus ();

    txarbiter #(.NREQ(NREQ), .LGNREQ(LGNREQ)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [LGNREQ-1:0] g;
        logic [31:0]       d;
    } exp_t;

    typedef struct {
        logic [NREQ-1:0]   stb;
        logic [31:0]       wd;
        logic [NREQ-1:0]   busy;
        logic              txstb;
        logic [31:0]       data;
        logic [LGNREQ-1:0] grant;
        logic              act;
    } vec_t;

    exp_t sbq[$];
    int   rise_q[$];
    int   glog[$];
    vec_t tbl[8];
    int   total = 0;
    int   bad = 0;
    int   tx_cnt = 0;
    int   xfers = 0;
    int   cyc = 0;
    logic stall = 1'b0;
    logic prev_stb = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int k, input logic [31:0] d);
        exp_t e;
        bus.i_req_stb[k]  = 1'b1;
        bus.i_req_data[k] = d;
        e.g = LGNREQ'(k);
        e.d = d;
        sbq.push_back(e);
    endtask

    // One clock: play txdata for this cycle, score any transfer, advance to the next cycle.
    task automatic cycle();
        exp_t e;
        bus.i_tx_busy = stall || (tx_cnt > 0);
        #1;
        if (bus.o_tx_stb && !prev_stb)
            rise_q.push_back(cyc);
        prev_stb = bus.o_tx_stb;
        if (bus.o_tx_stb && !bus.i_tx_busy) begin
            xfers++;
            glog.push_back(int'(bus.o_grant));
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL xfer_unexpected: got grant=%0d data=%h want no transfer", bus.o_grant, bus.o_tx_data);
            end else begin
                e = sbq.pop_front();
                chk("xfer_grant", 32'(bus.o_grant), 32'(e.g));
                chk("xfer_data", bus.o_tx_data, e.d);
            end
            tx_cnt = BUSYLEN;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
        end
        @(posedge clk);
        #1;
        cyc++;
        bus.i_req_stb = '0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((bus.o_active || sbq.size() != 0 || tx_cnt > 0) && n < 400) begin
            cycle();
            n++;
        end
        total++;
        if (n >= 400) begin
            bad++;
            $display("FAIL %s: got still busy after %0d cycles want idle", name, n);
        end
    endtask

    // Assert reset mid-cycle and confirm outputs drop before any clock edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_req_busy", 32'(bus.o_req_busy), 32'h0);
        chk("rst_tx_stb", 32'(bus.o_tx_stb), 32'h0);
        chk("rst_tx_data", bus.o_tx_data, 32'h0);
        chk("rst_grant", 32'(bus.o_grant), 32'(NREQ - 1));
        chk("rst_active", 32'(bus.o_active), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tx_cnt = 0;
        stall = 1'b0;
        prev_stb = 1'b0;
        bus.i_tx_busy = 1'b0;
        bus.i_req_stb = '0;
        sbq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int x0;
        int seq;
        bus.i_req_stb  = '0;
        bus.i_req_data = '0;
        bus.i_tx_busy  = 1'b0;
        do_reset();

        // single word from requester 2: strobe cycle 0, busy 1-2, stb at 2, WAIT exits at 6
        tbl[0] = '{4'b0100, 32'hDEADBEEF, 4'b0000, 1'b0, 32'h0,        2'd3, 1'b0};
        tbl[1] = '{4'b0000, 32'hDEADBEEF, 4'b0100, 1'b0, 32'h0,        2'd3, 1'b0};
        tbl[2] = '{4'b0000, 32'hDEADBEEF, 4'b0100, 1'b1, 32'hDEADBEEF, 2'd2, 1'b1};
        tbl[3] = '{4'b0000, 32'hDEADBEEF, 4'b0000, 1'b0, 32'hDEADBEEF, 2'd2, 1'b1};
        tbl[4] = '{4'b0000, 32'hDEADBEEF, 4'b0000, 1'b0, 32'hDEADBEEF, 2'd2, 1'b1};
        tbl[5] = '{4'b0000, 32'hDEADBEEF, 4'b0000, 1'b0, 32'hDEADBEEF, 2'd2, 1'b1};
        tbl[6] = '{4'b0000, 32'hDEADBEEF, 4'b0000, 1'b0, 32'hDEADBEEF, 2'd2, 1'b1};
        tbl[7] = '{4'b0000, 32'hDEADBEEF, 4'b0000, 1'b0, 32'hDEADBEEF, 2'd2, 1'b0};
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("vec%0d_busy", i), 32'(bus.o_req_busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d_stb", i), 32'(bus.o_tx_stb), 32'(tbl[i].txstb));
            chk($sformatf("vec%0d_data", i), bus.o_tx_data, tbl[i].data);
            chk($sformatf("vec%0d_grant", i), 32'(bus.o_grant), 32'(tbl[i].grant));
            chk($sformatf("vec%0d_active", i), 32'(bus.o_active), 32'(tbl[i].act));
            for (int k = 0; k < NREQ; k++)
                if (tbl[i].stb[k]) drive(k, tbl[i].wd);
            cycle();
        end
        wait_idle("single_idle");

        // simultaneous: order 0..3, each grant BUSYLEN+3 cycles after the previous
        do_reset();
        rise_q.delete();
        drive(0, 32'h00000000);
        drive(1, 32'h11111111);
        drive(2, 32'h22222222);
        drive(3, 32'h33333333);
        cycle();
        wait_idle("simul_idle");
        chk("simul_rises", 32'(rise_q.size()), 32'd4);
        for (int i = 1; i < rise_q.size(); i++)
            chk("simul_spacing", 32'(rise_q[i] - rise_q[i-1]), 32'(BUSYLEN + 3));

        // fairness: 1 and 3 refill whenever free; grants must alternate 1,3,...
        glog.delete();
        x0 = xfers;
        seq = 0;
        for (int n = 0; n < 1000 && (xfers - x0) < 20; n++) begin
            if (!bus.o_req_busy[1]) begin drive(1, 32'h01000000 | 32'(seq)); seq++; end
            if (!bus.o_req_busy[3]) begin drive(3, 32'h03000000 | 32'(seq)); seq++; end
            cycle();
        end
        chk("fair_count", 32'((xfers - x0) >= 20), 32'd1);
        wait_idle("fair_idle");
        for (int i = 0; i < glog.size(); i++)
            chk("fair_grant", 32'(glog[i]), (i % 2 == 0) ? 32'd1 : 32'd3);

        // stall: word held constant for 50 busy cycles, then transfers at once
        stall = 1'b1;
        drive(0, 32'hC0FFEE00);
        cycle();
        cycle();
        x0 = xfers;
        for (int i = 0; i < 50; i++) begin
            chk("stall_stb", 32'(bus.o_tx_stb), 32'd1);
            chk("stall_data", bus.o_tx_data, 32'hC0FFEE00);
            cycle();
        end
        chk("stall_noxfer", 32'(xfers), 32'(x0));
        stall = 1'b0;
        cycle();
        chk("stall_xfer", 32'(xfers), 32'(x0 + 1));
        wait_idle("stall_idle");

        // ignored strobe: second word while busy must never appear
        x0 = xfers;
        drive(1, 32'h0000000A);
        cycle();
        chk("ign_busy", 32'(bus.o_req_busy[1]), 32'd1);
        bus.i_req_stb[1]  = 1'b1;
        bus.i_req_data[1] = 32'h0000000B;
        cycle();
        wait_idle("ign_idle");
        for (int i = 0; i < 10; i++) cycle();
        chk("ign_count", 32'(xfers), 32'(x0 + 1));

        // reset in WAIT with buffers 1 and 2 full: both dropped, requester 0 wins after
        drive(3, 32'h33330000);
        cycle();
        cycle();
        cycle();
        bus.i_req_stb[1]  = 1'b1;
        bus.i_req_data[1] = 32'h1111DEAD;
        bus.i_req_stb[2]  = 1'b1;
        bus.i_req_data[2] = 32'h2222DEAD;
        cycle();
        chk("mid_busy", 32'(bus.o_req_busy), 32'h6);
        chk("mid_active", 32'(bus.o_active), 32'd1);
        do_reset();
        drive(0, 32'h0000F00D);
        drive(2, 32'h2222F00D);
        cycle();
        wait_idle("post_rst_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/txarbiter.md
# txarbiter

Round-robin arbiter that shares one `txdata` serial-word transmitter among `NREQ` independent word producers, e.g. several `chgdetector` instances. Each requester gets a one-word holding buffer with the same stb/busy handshake that `txdata` presents. The arbiter grants one buffered word at a time to the transmitter and waits for the transmitter to finish before issuing the next. It sits between the producers and `txdata` in `thedesign`-style top levels.

## Interface
- `NREQ`, 4: number of requesters; legal range 2..8.
- `LGNREQ`, 2: width of the grant index; must equal ceil(log2(NREQ)).
- `i_clk`  in  1  system clock; all state changes on the rising edge.
- `i_reset`  in  1  reset; asynchronous, active-high.
- `i_req_stb`  in  NREQ  per-requester word strobe.
- `i_req_data`  in  32*NREQ  requester k's word on bits [32k+31:32k].
- `o_req_busy`  out  NREQ  requester k's buffer is full; its strobe is ignored.
- `o_tx_stb`  out  1  word-valid strobe to `txdata`.
- `o_tx_data`  out  32  word to `txdata`; stable while `o_tx_stb` is high.
- `i_tx_busy`  in  1  `txdata` busy flag.
- `o_grant`  out  LGNREQ  index of the requester currently or last served.
- `o_active`  out  1  high whenever the state is not IDLE.

## Operation
- Requester buffer k:
  - Loads `i_req_data[k]` and sets `o_req_busy[k]` when `i_req_stb[k] && !o_req_busy[k]`.
  - Clears when its word is accepted by `txdata`.
  - While `o_req_busy[k]` is high, strobes are ignored and the data is not overwritten.
- Transmit handshake: a word transfers to `txdata` on any cycle with `o_tx_stb && !i_tx_busy`. `txdata` raises `i_tx_busy` in the cycle after that transfer.
- States:
  - IDLE: if any buffer is full, choose the first full buffer searching from `(o_grant+1) mod NREQ` upward with wrap. Register its index into `o_grant`, load its word into `o_tx_data`, set `o_tx_stb`, then go to SEND. If no buffer is full, stay in IDLE.
  - SEND: hold `o_tx_stb` and `o_tx_data`. On transfer, clear `o_tx_stb`, clear buffer `o_grant`, and go to GUARD.
  - GUARD: one cycle; `i_tx_busy` is ignored. Go to WAIT.
  - WAIT: stay while `i_tx_busy` is high. When it is low, go to IDLE.
- Fairness: after requester k is served, every other full buffer is served before k is served again.
- Arbitration happens only in IDLE. A buffer that fills during SEND, GUARD or WAIT is not considered until the next IDLE.
- A buffer that is currently granted cannot be reloaded until it clears. There is no write/clear collision, because a write requires `!o_req_busy[k]`.
- Same cycle as a clear: a strobe from requester k in the clear cycle is ignored, since busy is still high. The strobe is accepted from the next cycle on.

## Timing
- Reset values:
  - state = IDLE
  - `o_req_busy` = 0, buffers = 0
  - `o_tx_stb` = 0, `o_tx_data` = 0
  - `o_grant` = NREQ-1, so requester 0 wins first
  - `o_active` = 0
- Reset effect: asserting `i_reset` forces every output to its reset value immediately, without waiting for a clock edge. Any word held in a buffer or in flight is dropped. `txdata` is reset separately.
- Latency, with `txdata` idle (cycle numbers relative to the strobe at cycle 0):
  - cycle 0: `i_req_stb[k]` high.
  - cycle 1: `o_req_busy[k]` = 1.
  - cycle 2: `o_tx_stb` = 1, and the word transfers.
  - cycle 3: `o_req_busy[k]` = 0, `o_tx_stb` = 0, state GUARD.
- Minimum spacing between two `o_tx_stb` rising edges is the `txdata` busy time plus 3 cycles (GUARD, WAIT exit, IDLE grant).
- If `i_tx_busy` is already high when SEND is entered, `o_tx_stb` stays high with constant data until busy drops.
- `o_grant` changes only on the IDLE-to-SEND transition.
- `o_active` is a registered decode of state: high in SEND, GUARD and WAIT.

## Test plan
- Single word:
  - Stimulus: `txdata` idle; strobe requester 2 once with 0xDEADBEEF.
  - Required response: `o_tx_stb` high exactly at cycle 2 with `o_tx_data`=0xDEADBEEF and `o_grant`=2; `o_req_busy[2]` high during cycles 1-2 only.
- Simultaneous requests:
  - Stimulus: strobe all four requesters in the same cycle with 0x0, 0x11111111, 0x22222222 and 0x33333333.
  - Required response: words are issued in order 0,1,2,3; each new `o_tx_stb` follows only after `i_tx_busy` falls.
- Fairness under load:
  - Stimulus: requesters 1 and 3 re-strobe whenever `!o_req_busy`; run 20 transfers.
  - Required response: grants strictly alternate 1,3,1,3; requesters 0 and 2 are never granted.
- Stall:
  - Stimulus: hold `i_tx_busy` high for 50 cycles while requester 0 is full.
  - Required response: `o_tx_stb` and `o_tx_data` stay constant; the transfer occurs on the first cycle with `i_tx_busy` low.
- Ignored strobe:
  - Stimulus: strobe requester 1 with 0xA, then strobe it with 0xB while `o_req_busy[1]`=1.
  - Required response: only 0xA is sent.
- Reset mid-operation:
  - Stimulus: assert `i_reset` during WAIT with two buffers full.
  - Required response: all outputs are at their reset values before the next edge; after release, the first grant goes to requester 0.
